// File: rtl/user_io_host.sv
// user_io_host: SPI master issuing user_io command frames; define USER_IO_HOST_READBACK_EN for MISO readback.
module user_io_host #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        spi_ss_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  bit_cnt;
  logic [2:0]  len, len_c;
  logic [38:0] sr;
  logic [31:0] data_m;
  logic        half_done, last_bit;
  assign cmd_ready = state == IDLE;
  assign busy      = ~cmd_ready;
  assign half_done = cnt == 8'd0;
  assign last_bit  = bit_cnt == {len, 3'b111};
  // bytes beyond the clamped length are zeroed so MOSI idles low after the last bit
  always_comb begin
    len_c = cmd_len > 3'd4 ? 3'd4 : cmd_len;
    for (int i = 0; i < 4; i++) data_m[8*i +: 8] = 3'(i) < len_c ? cmd_data[8*i +: 8] : 8'h00;
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      len      <= '0;
      sr       <= '0;
      spi_ss_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      cnt <= half_done ? DIV_M1 : cnt - 8'd1;
      case (state)
        IDLE: begin
          cnt <= DIV_M1;
          if (cmd_valid) begin
            state    <= SETUP;
            bit_cnt  <= '0;
            len      <= len_c;
            sr       <= {cmd_code[6:0], data_m[7:0], data_m[15:8], data_m[23:16], data_m[31:24]};
            spi_ss_n <= 1'b0;
            spi_mosi <= cmd_code[7];
          end
        end
        SETUP: if (half_done) begin
          state   <= HIGH;
          spi_sck <= 1'b1;
        end
        HIGH: if (half_done) begin
          state    <= LOW;
          spi_sck  <= 1'b0;
          spi_mosi <= sr[38];
          sr       <= {sr[37:0], 1'b0};
        end
        LOW: if (half_done) begin
          if (last_bit) begin
            state    <= GAP;
            spi_ss_n <= 1'b1;
            spi_mosi <= 1'b0;
          end else begin
            state   <= HIGH;
            spi_sck <= 1'b1;
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        GAP: if (half_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef USER_IO_HOST_READBACK_EN
  logic [7:0] rx;
  logic       rd_pend, to_high, high_end, payload_end;
  assign to_high     = half_done && (state == SETUP || (state == LOW && !last_bit));
  assign high_end    = half_done && state == HIGH;
  assign payload_end = &bit_cnt[2:0] && |bit_cnt[5:3];
  // MISO is sampled on the edge that raises SCK; the strobe lands one cycle into the following LOW
  always_ff @(posedge clk_sys)
    if (reset) begin
      rx       <= '0;
      rd_data  <= '0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_pend;
      rd_pend  <= high_end && payload_end;
      if (to_high) rx <= {rx[6:0], spi_miso};
      if (high_end && payload_end) rd_data <= rx;
    end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rd_data     = 8'h00;
  assign rd_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_user_io_host.sv
// tb_user_io_host: table-driven frames with MOSI/readback scoreboards plus back-to-back and reset-abort sequences.
module tb_user_io_host;
  localparam int DIV = 4;
`ifdef USER_IO_HOST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef struct {
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] data;
    logic [31:0] resp;
    int          nlen;
    int          bits;
    int          cyc;
  } vec_t;
  logic        clk_sys = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [7:0]  cmd_code = '0;
  logic [2:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, rd_valid, busy, spi_ss_n, spi_sck, spi_mosi, spi_miso;
  logic [7:0]  rd_data;
  int          checks = 0, errors = 0;
  int          busy_cnt = 0, ss_cnt = 0, rises = 0, strobes = 0, first_rise = 0;
  logic [7:0]  mosi_q[$], rd_q[$];
  logic [7:0]  exp_rd = 8'h00;
  logic [39:0] resp_bits = '0;
  logic [5:0]  ridx = '0;
  logic        sck_d = 1'b0;
  logic [7:0]  mo_sr = '0;
  int          mo_bits = 0;
  vec_t        vt[6];

  always #5 clk_sys = ~clk_sys;

  user_io_host #(.CLK_DIV(DIV)) dut (
    .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_data(cmd_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .spi_ss_n(spi_ss_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // responder: presents the next bit after every SCK fall, like a mode-0 slave
  assign spi_miso = ridx < 6'd40 ? resp_bits[6'd39 - ridx] : 1'b0;

  always @(posedge clk_sys) begin
    sck_d <= spi_sck;
    if (spi_ss_n) begin
      ridx    <= '0;
      mo_bits <= 0;
    end else begin
      if (sck_d && !spi_sck) ridx <= ridx + 6'd1;
      if (!sck_d && spi_sck) begin
        rises++;
        mo_sr   <= {mo_sr[6:0], spi_mosi};
        mo_bits <= mo_bits + 1;
        if (mo_bits % 8 == 7) begin
          if (mosi_q.size() == 0) chk("mosi_extra_byte", 32'({mo_sr[6:0], spi_mosi}), 32'hFFFF_FFFF);
          else chk("mosi_byte", 32'({mo_sr[6:0], spi_mosi}), 32'(mosi_q.pop_front()));
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (busy) busy_cnt++;
    if (!spi_ss_n) ss_cnt++;
    if (spi_sck && first_rise == 0) first_rise = busy_cnt;
    if (spi_ss_n && spi_sck) chk("sck_low_while_ss_high", 32'(spi_sck), 32'd0);
    if (rd_valid) begin
      strobes++;
      if (rd_q.size() == 0) chk("rd_extra_strobe", 32'(rd_data), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
  end

  task automatic push_frame(input logic [7:0] code, input logic [31:0] data, input logic [31:0] resp, input int nlen);
    mosi_q.push_back(code);
    for (int i = 0; i < nlen; i++) begin
      mosi_q.push_back(8'(data >> (8 * i)));
      if (RB) begin
        rd_q.push_back(8'(resp >> (8 * i)));
        exp_rd = 8'(resp >> (8 * i));
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    resp_bits = {8'h00, v.resp[7:0], v.resp[15:8], v.resp[23:16], v.resp[31:24]};
    @(negedge clk_sys);
    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_code  = v.code;
    cmd_len   = v.len;
    cmd_data  = v.data;
    push_frame(v.code, v.data, v.resp, v.nlen);
    busy_cnt = 0; ss_cnt = 0; rises = 0; strobes = 0; first_rise = 0;
    @(posedge clk_sys);
    #1;
    cmd_valid = 1'b0;
    cmd_code  = 8'($urandom);
    cmd_data  = $urandom;
    cmd_len   = 3'($urandom);
    wait_ready();
    chk("busy_cycles", 32'(busy_cnt), 32'(v.cyc));
    chk("ss_low_cycles", 32'(ss_cnt), 32'(v.cyc - DIV));
    chk("sck_rises", 32'(rises), 32'(v.bits));
    chk("first_rise", 32'(first_rise), 32'(DIV + 1));
    chk("rd_strobes", 32'(strobes), 32'(RB ? v.nlen : 0));
    chk("mosi_q_left", 32'(mosi_q.size()), 32'd0);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap;
    vt[0] = '{8'h15, 3'd1, 32'h0000_005A, 32'h0000_00C3, 1, 16, 136};
    vt[1] = '{8'h1E, 3'd4, 32'h1234_5678, 32'h0F1E_2D3C, 4, 40, 328};
    vt[2] = '{8'h14, 3'd2, 32'h0000_0000, 32'h0000_3CA5, 2, 24, 200};
    vt[3] = '{8'h1E, 3'd7, 32'h1234_5678, 32'h55AA_33CC, 4, 40, 328};
    vt[4] = '{8'h01, 3'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 8, 72};
    vt[5] = '{8'h05, 3'd3, 32'h00AB_CDEF, 32'h0080_7F01, 3, 32, 264};
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ss_n", 32'(spi_ss_n), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_cmd(vt[i]);
    // back-to-back: valid held high across both frames
    resp_bits = '0;
    @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_code = 8'h15; cmd_len = 3'd1; cmd_data = 32'h5A;
    push_frame(8'h15, 32'h5A, 32'h0, 1);
    @(posedge clk_sys);
    #1;
    cmd_code = 8'h02; cmd_data = 32'h33;
    push_frame(8'h02, 32'h33, 32'h0, 1);
    n = 0;
    while (!spi_ss_n && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    gap = 0;
    while (spi_ss_n && gap < 100) begin
      gap++;
      @(negedge clk_sys);
    end
    cmd_valid = 1'b0;
    chk("b2b_ss_gap", 32'(gap), 32'(DIV + 1));
    @(negedge clk_sys);
    wait_ready();
    chk("b2b_mosi_q_left", 32'(mosi_q.size()), 32'd0);
    chk("b2b_rd_q_left", 32'(rd_q.size()), 32'd0);
    // reset during bit 11 of a two-byte frame
    resp_bits = {8'h00, 8'h77, 8'h66, 16'h0};
    @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_code = 8'h14; cmd_len = 3'd2; cmd_data = 32'h0000_BBAA;
    push_frame(8'h14, 32'h0000_BBAA, 32'h0000_6677, 2);
    rises = 0; strobes = 0;
    @(posedge clk_sys);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rises < 11 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("abort_reached_bit11", 32'(rises), 32'd11);
    reset = 1'b1;
    mosi_q.delete();
    rd_q.delete();
    exp_rd = 8'h00;
    @(negedge clk_sys);
    chk("abort_ss_n", 32'(spi_ss_n), 32'd1);
    chk("abort_sck", 32'(spi_sck), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_mosi", 32'(spi_mosi), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("abort_no_strobe", 32'(strobes), 32'd0);
    run_cmd(vt[2]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
